// File: rtl/wb_pkg.sv
// Shared types and default widths for the
// Wishbone peripheral-port arbiter.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  localparam int CTRLS_DEF   = 2;
  localparam int ADRW_DEF    = 4;
  localparam int DATW_DEF    = 8;
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: searches
// from last+1 upward with wrap-around.
module rr_pick
  import wb_pkg::*;
#(
  parameter int N    = CTRLS_DEF,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_i) + i) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IdxW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with an
// ack watchdog that turns a hang into an error.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int Ctrls   = CTRLS_DEF,
  parameter int AdrW    = ADRW_DEF,
  parameter int DatW    = DATW_DEF,
  parameter int Timeout = TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Ctrls-1:0]      ctrl_stb_i,
  input  logic [Ctrls-1:0]      ctrl_we_i,
  input  logic [Ctrls*AdrW-1:0] ctrl_adr_i,
  input  logic [Ctrls*DatW-1:0] ctrl_dat_i,
  output logic [DatW-1:0]       ctrl_dat_o,
  output logic [Ctrls-1:0]      ctrl_ack_o,
  output logic [Ctrls-1:0]      ctrl_err_o,
  output logic                  peri_stb_o,
  output logic                  peri_we_o,
  output logic [AdrW-1:0]       peri_adr_o,
  output logic [DatW-1:0]       peri_dat_o,
  input  logic [DatW-1:0]       peri_dat_i,
  input  logic                  peri_ack_i,
  output logic [Ctrls-1:0]      grant_o
);

  localparam int IdxW = $clog2(Ctrls);
  localparam int CntW =
    (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam logic [CntW-1:0] TMO = CntW'(Timeout);

  arb_state_e      state;
  logic [IdxW-1:0] last;
  logic [CntW-1:0] cnt;

  logic [Ctrls-1:0] pick_gnt;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_any;

  rr_pick #(
    .N    (Ctrls),
    .IdxW (IdxW)
  ) u_pick (
    .req_i  (ctrl_stb_i),
    .last_i (last),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last       <= IdxW'(Ctrls - 1);
      cnt        <= '0;
      ctrl_dat_o <= '0;
      ctrl_ack_o <= '0;
      ctrl_err_o <= '0;
      peri_stb_o <= 1'b0;
      peri_we_o  <= 1'b0;
      peri_adr_o <= '0;
      peri_dat_o <= '0;
      grant_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            peri_we_o  <= ctrl_we_i[pick_idx];
            peri_adr_o <=
              ctrl_adr_i[pick_idx*AdrW +: AdrW];
            peri_dat_o <=
              ctrl_dat_i[pick_idx*DatW +: DatW];
            grant_o    <= pick_gnt;
            peri_stb_o <= 1'b1;
            last       <= pick_idx;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // ack has priority over a same-cycle expiry
          if (peri_ack_i) begin
            ctrl_dat_o <= peri_dat_i;
            ctrl_ack_o <= grant_o;
            peri_stb_o <= 1'b0;
            state      <= RESP;
          end else if (Timeout != 0 && cnt == TMO) begin
            ctrl_dat_o <= '0;
            ctrl_err_o <= grant_o;
            peri_stb_o <= 1'b0;
            state      <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ctrl_ack_o <= '0;
          ctrl_err_o <= '0;
          grant_o    <= '0;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a default
// instance and a Timeout=4 instance.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  stb, stb_t, we;
  logic [7:0]  adr;
  logic [15:0] wdat;
  logic [7:0]  pdat;
  logic        pack, ack_t;

  logic [7:0] m_dat, m_padr_w, m_pdat;
  logic [3:0] m_padr;
  logic [1:0] m_ack, m_err, m_gnt;
  logic       m_pstb, m_pwe;

  logic [7:0] t_dat, t_pdat;
  logic [3:0] t_padr;
  logic [1:0] t_ack, t_err, t_gnt;
  logic       t_pstb, t_pwe;

  wb_arbiter u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ctrl_stb_i (stb),
    .ctrl_we_i  (we),
    .ctrl_adr_i (adr),
    .ctrl_dat_i (wdat),
    .ctrl_dat_o (m_dat),
    .ctrl_ack_o (m_ack),
    .ctrl_err_o (m_err),
    .peri_stb_o (m_pstb),
    .peri_we_o  (m_pwe),
    .peri_adr_o (m_padr),
    .peri_dat_o (m_pdat),
    .peri_dat_i (pdat),
    .peri_ack_i (pack),
    .grant_o    (m_gnt)
  );

  wb_arbiter #(.Timeout(4)) u_tmo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ctrl_stb_i (stb_t),
    .ctrl_we_i  (we),
    .ctrl_adr_i (adr),
    .ctrl_dat_i (wdat),
    .ctrl_dat_o (t_dat),
    .ctrl_ack_o (t_ack),
    .ctrl_err_o (t_err),
    .peri_stb_o (t_pstb),
    .peri_we_o  (t_pwe),
    .peri_adr_o (t_padr),
    .peri_dat_o (t_pdat),
    .peri_dat_i (pdat),
    .peri_ack_i (ack_t),
    .grant_o    (t_gnt)
  );

  assign m_padr_w = {4'h0, m_padr};

  int checks = 0;
  int errors = 0;
  int last_g = 1;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] dat;
  } resp_t;

  resp_t mq[$];
  resp_t tq[$];
  resp_t me, te;

  always @(negedge clk) begin
    if (rst_n && (m_ack | m_err) != 2'b00) begin
      if (mq.size() == 0) begin
        chk("m_unexp", {m_ack, m_err}, 0);
      end else begin
        me = mq.pop_front();
        chk("m_ack", m_ack, me.ack);
        chk("m_err", m_err, me.err);
        chk("m_dat", m_dat, me.dat);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (t_ack | t_err) != 2'b00) begin
      if (tq.size() == 0) begin
        chk("t_unexp", {t_ack, t_err}, 0);
      end else begin
        te = tq.pop_front();
        chk("t_ack", t_ack, te.ack);
        chk("t_err", t_err, te.err);
        chk("t_dat", t_dat, te.dat);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic txn(int k, logic w,
                     logic [3:0] a,
                     logic [7:0] d,
                     int waits,
                     logic [7:0] rd);
    logic [1:0] g;
    g = 2'b01 << k;
    stb[k]         = 1'b1;
    we[k]          = w;
    adr[k*4 +: 4]  = a;
    wdat[k*8 +: 8] = d;
    mq.push_back('{ack: g, err: 2'b00, dat: rd});
    cyc();
    for (int i = 0; i <= waits; i++) begin
      chk("pstb", m_pstb, 1);
      chk("gnt", m_gnt, g);
      chk("padr", m_padr_w, {4'h0, a});
      chk("pdat", m_pdat, d);
      chk("pwe", m_pwe, w);
      chk("early", m_ack | m_err, 0);
      if (i == waits) begin
        pack = 1'b1;
        pdat = rd;
      end
      cyc();
    end
    pack = 1'b0;
    chk("lat_ack", m_ack, g);
    stb[k] = 1'b0;
    cyc();
    chk("idle_clr", {m_ack, m_gnt, 1'b0, m_pstb}, 0);
    last_g = k;
  endtask

  initial begin
    int t, gi;
    logic [1:0] g;
    stb   = '0;
    stb_t = '0;
    we    = '0;
    adr   = '0;
    wdat  = '0;
    pdat  = '0;
    pack  = 1'b0;
    ack_t = 1'b0;
    repeat (2) cyc();
    chk("rst_pstb", m_pstb, 0);
    chk("rst_gnt", m_gnt, 0);
    chk("rst_resp", {m_ack, m_err}, 0);
    chk("rst_dat", m_dat, 0);
    chk("rst_padr", m_padr_w, 0);
    rst_n = 1'b1;
    cyc();

    pack  = 1'b1;
    ack_t = 1'b1;
    pdat  = 8'hEE;
    cyc();
    pack  = 1'b0;
    ack_t = 1'b0;
    chk("ign_m", {m_ack, m_err}, 0);
    chk("ign_t", {t_ack, t_err}, 0);
    cyc();
    chk("ign_m2", {m_ack, m_err, m_dat}, 0);

    txn(0, 1'b0, 4'd3, 8'h00, 0, 8'hA5);
    txn(1, 1'b1, 4'd9, 8'h5C, 5, 8'h12);

    stb  = 2'b11;
    we   = 2'b11;
    adr  = 8'h21;
    wdat = {8'h22, 8'h11};
    for (int n = 0; n < 4; n++) begin
      t = 0;
      while (!m_pstb && t < 10) begin
        cyc();
        t++;
      end
      if (t >= 10) chk("f_timeout", m_pstb, 1);
      gi = (last_g + 1) % 2;
      g  = 2'b01 << gi;
      chk("f_gnt", m_gnt, g);
      chk("f_pdat", m_pdat,
          (gi == 1) ? 8'h22 : 8'h11);
      pack = 1'b1;
      pdat = 8'h40 + 8'(n);
      mq.push_back('{ack: g, err: 2'b00,
                     dat: 8'h40 + 8'(n)});
      cyc();
      pack   = 1'b0;
      last_g = gi;
      if (n == 3) stb = 2'b00;
    end
    cyc();
    cyc();

    txn(0, 1'b0, 4'd1, 8'h00, 0, 8'h66);
    stb = 2'b11;
    cyc();
    chk("r_gnt1", m_gnt, 2'b10);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("r_pstb", m_pstb, 0);
    chk("r_gnt", m_gnt, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("r_gnt0", m_gnt, 2'b01);
    pack = 1'b1;
    pdat = 8'h77;
    mq.push_back('{ack: 2'b01, err: 2'b00,
                   dat: 8'h77});
    cyc();
    pack = 1'b0;
    stb  = 2'b00;
    cyc();
    cyc();

    stb_t[0] = 1'b1;
    tq.push_back('{ack: 2'b01, err: 2'b00,
                   dat: 8'h3C});
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk("ta_pstb", t_pstb, 1);
      chk("ta_quiet", t_ack | t_err, 0);
    end
    ack_t = 1'b1;
    pdat  = 8'h3C;
    cyc();
    ack_t = 1'b0;
    chk("ta_ack", t_ack, 2'b01);
    chk("ta_noerr", t_err, 0);
    stb_t = 2'b00;
    cyc();
    cyc();

    stb_t[1] = 1'b1;
    tq.push_back('{ack: 2'b00, err: 2'b10,
                   dat: 8'h00});
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk("to_pstb", t_pstb, 1);
      chk("to_quiet", t_ack | t_err, 0);
    end
    cyc();
    chk("to_err", t_err, 2'b10);
    chk("to_noack", t_ack, 0);
    chk("to_dat", t_dat, 0);
    stb_t = 2'b00;
    cyc();
    chk("to_clr", {t_gnt, 1'b0, t_pstb}, 0);

    repeat (3) cyc();
    chk("mq_empty", mq.size(), 0);
    chk("tq_empty", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares one Wishbone B4 peripheral port between `Ctrls` controllers, e.g. the UART and SPI bridges both reaching the peripheral bus where the blinkenlight and other peripherals sit. It grants one controller per transaction, forwards that controller's request, and returns the acknowledge and read data only to that controller. A watchdog converts a missing acknowledge into an error response, so a dead peripheral cannot lock the bus.

## Interface
- `Ctrls`, 2: number of controllers, 2..8.
- `AdrW`, 4: address width.
- `DatW`, 8: data width.
- `Timeout`, 255: maximum wait for `peri_ack_i`, in cycles; 0 disables the watchdog.

- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `ctrl_stb_i` input `Ctrls`: request strobe per controller.
- `ctrl_we_i` input `Ctrls`: write enable per controller.
- `ctrl_adr_i` input `Ctrls*AdrW`: packed addresses; controller k occupies bits `[k*AdrW +: AdrW]`.
- `ctrl_dat_i` input `Ctrls*DatW`: packed write data, same packing.
- `ctrl_dat_o` output `DatW`: read data, shared by all controllers, valid while an ack is asserted.
- `ctrl_ack_o` output `Ctrls`: one-cycle acknowledge pulse.
- `ctrl_err_o` output `Ctrls`: one-cycle timeout error pulse.
- `peri_stb_o` output 1: strobe to the peripheral.
- `peri_we_o` output 1: write enable to the peripheral.
- `peri_adr_o` output `AdrW`: address to the peripheral.
- `peri_dat_o` output `DatW`: write data to the peripheral.
- `peri_dat_i` input `DatW`: read data from the peripheral.
- `peri_ack_i` input 1: acknowledge from the peripheral.
- `grant_o` output `Ctrls`: one-hot owner of the bus, for debug LEDs.

## Operation
- All outputs are registered.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - last-granted pointer `Ctrls-1`, so controller 0 wins first;
  - watchdog counter 0.
- States and transitions:
  - **IDLE**: if any `ctrl_stb_i` is high, pick the winner, searching from last+1 upward with wrap-around. Latch its we/adr/dat into the `peri_*` registers, set `grant_o`, set `peri_stb_o`=1, update last, go to BUSY.
  - **BUSY**: hold `peri_*` stable and count the watchdog up.
    - `peri_ack_i`=1: capture `peri_dat_i` into `ctrl_dat_o`, pulse `ctrl_ack_o[g]`, clear `peri_stb_o`, go to RESP.
    - Otherwise, if `Timeout`≠0 and the count reaches `Timeout`: pulse `ctrl_err_o[g]`, set `ctrl_dat_o`=0, clear `peri_stb_o`, go to RESP.
  - **RESP**: the ack/err pulse is visible for this one cycle. Then clear the pulse and `grant_o`, reset the watchdog, go to IDLE.
- Controller obligations:
  - Hold stb/we/adr/dat stable until its ack or err is seen.
  - Drop stb in the cycle after the ack or err.
- A granted controller dropping stb early does not abort the transaction; the response is still produced.
- Non-granted controllers' inputs are ignored until the next IDLE.
- `peri_ack_i` outside BUSY is ignored.
- If `peri_ack_i` arrives on the same cycle the watchdog expires, ack wins and err is not raised.
- Ack and err are never both high, and at most one controller bit is high at a time.
- Async reset in any state returns to IDLE immediately and drops `peri_stb_o`. A transaction in flight is lost silently, with no ack and no err.

## Timing
- Zero-wait peripheral (ack in the first BUSY cycle): request in cycle 0 → `peri_stb_o` in cycle 1 → `ctrl_ack_o` in cycle 2. Request to ack latency is 2 cycles.
- A peripheral with n wait states gives a latency of 2+n cycles.
- Back-to-back transactions: at least 3 cycles per transaction (IDLE, BUSY, RESP).
- Watchdog error: raised in cycle `Timeout`+2 after the request.
- Fairness: under continuous requests from all controllers, each is granted once every `Ctrls` transactions.

## Structure
- Shared package `wb_pkg`:
  - enum `arb_state_e` {IDLE, BUSY, RESP};
  - default width constants.
- Sub-module `rr_pick`:
  - combinational;
  - inputs: request vector, last pointer;
  - outputs: one-hot grant, index, any-request flag.
- The watchdog counter is `$clog2(Timeout+1)` bits wide and saturates, never wraps.

## Test plan
- **Single read:** ctrl 0 reads adr 3; peripheral acks in its first cycle with dat 0xA5 → `ctrl_ack_o`=01 in cycle 2, `ctrl_dat_o`=0xA5; `ctrl_ack_o[1]` stays 0.
- **Fairness:** ctrl 0 and ctrl 1 both hold stb continuously (writes 0x11 and 0x22) → grants alternate 0,1,0,1; `peri_dat_o` alternates 0x11, 0x22.
- **Wait states:** peripheral inserts 5 wait states → `peri_adr_o` and `peri_dat_o` stay stable for 6 cycles; ack arrives in cycle 7.
- **Timeout:** `Timeout`=4 with no `peri_ack_i` → `ctrl_err_o[g]`=1 in cycle 6, `ctrl_dat_o`=0; ack coincident with expiry gives ack, not err.
- **Reset mid-transaction:** `rst_ni` pulled low mid-BUSY → `peri_stb_o` and `grant_o` are 0 immediately; after release, ctrl 0 wins the first grant again.
- **Ignored ack:** `peri_ack_i` pulsed while in IDLE → no ack or err output.
